// File: rtl/temp_level_classifier_pkg.sv
// temp_level_classifier_pkg: level encodings shared with the pump/valve FSM
package temp_level_classifier_pkg;
    typedef enum logic [1:0] {
        LVL_NORMAL = 2'b00,
        LVL_MEDIA  = 2'b01,
        LVL_ALTA   = 2'b10
    } level_t;
endpackage

// File: rtl/level_persist_filter.sv
// level_persist_filter: commits a candidate level only after PERSIST consecutive agreeing valid samples
module level_persist_filter #(
    parameter int LVL_W   = 2,
    parameter int PERSIST = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [LVL_W-1:0] cand,
    input  logic             in_valid,
    input  logic [LVL_W-1:0] level,
    output logic             commit,
    output logic [LVL_W-1:0] new_level
);
    localparam int CW = $clog2(PERSIST + 1);
    logic [LVL_W-1:0] pend;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    n;
    logic             differs;
    assign differs   = cand != level;
    assign n         = (cand == pend) ? cnt + CW'(1) : CW'(1);
    assign commit    = in_valid && differs && n == CW'(PERSIST);
    assign new_level = cand;
    // track the pending candidate and its run length; idle cycles hold the run
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend <= '0;
            cnt  <= '0;
        end else if (in_valid) begin
            if (!differs) begin
                cnt <= '0;
            end else begin
                pend <= cand;
                cnt  <= (n == CW'(PERSIST)) ? '0 : n;
            end
        end
    end
endmodule

// File: rtl/temp_level_classifier.sv
// temp_level_classifier: hysteretic, persistence-filtered temperature level classifier with sticky alarm
module temp_level_classifier
    import temp_level_classifier_pkg::*;
#(
    parameter int ADC_W   = 8,
    parameter int TH_MED  = 96,
    parameter int TH_ALTA = 192,
    parameter int HYST    = 8,
    parameter int PERSIST = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [ADC_W-1:0] adc_data,
    input  logic             adc_valid,
    input  logic             fault_clr,
    output logic             T_media,
    output logic             T_alta,
    output logic [1:0]       level,
    output logic             alarm_latched
);
    if (HYST > TH_MED || HYST >= TH_ALTA - TH_MED || PERSIST < 1) begin : g_bad_params
        $error("temp_level_classifier: illegal HYST/threshold/PERSIST combination");
    end
    localparam logic [ADC_W-1:0] TH_MED_R  = ADC_W'(TH_MED);
    localparam logic [ADC_W-1:0] TH_ALTA_R = ADC_W'(TH_ALTA);
    localparam logic [ADC_W-1:0] TH_MED_F  = ADC_W'(TH_MED - HYST);
    localparam logic [ADC_W-1:0] TH_ALTA_F = ADC_W'(TH_ALTA - HYST);
    level_t     cand;
    logic       commit;
    logic [1:0] new_level;
    // rising thresholds first, then the lowered falling thresholds that hold the current level
    always_comb begin
        cand = (adc_data >= TH_ALTA_R) ? LVL_ALTA :
               (level == LVL_ALTA && adc_data >= TH_ALTA_F) ? LVL_ALTA :
               (adc_data >= TH_MED_R) ? LVL_MEDIA :
               (level != LVL_NORMAL && adc_data >= TH_MED_F) ? LVL_MEDIA : LVL_NORMAL;
    end
    level_persist_filter #(
        .LVL_W   (2),
        .PERSIST (PERSIST)
    ) u_filter (
        .clk       (clk),
        .reset     (reset),
        .cand      (cand),
        .in_valid  (adc_valid),
        .level     (level),
        .commit    (commit),
        .new_level (new_level)
    );
    // level register with registered one-hot decode
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level   <= LVL_NORMAL;
            T_media <= 1'b0;
            T_alta  <= 1'b0;
        end else if (commit) begin
            level   <= new_level;
            T_media <= new_level == LVL_MEDIA;
            T_alta  <= new_level == LVL_ALTA;
        end
    end
    // sticky alarm: ALTA entry sets and wins; clearing only allowed outside ALTA
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alarm_latched <= 1'b0;
        end else if (commit && new_level == LVL_ALTA) begin
            alarm_latched <= 1'b1;
        end else if (fault_clr && level != LVL_ALTA) begin
            alarm_latched <= 1'b0;
        end
    end
endmodule

// File: tb/tb_temp_level_classifier.sv
// tb_temp_level_classifier: directed self-checking bench for temp_level_classifier
module tb_temp_level_classifier;
    logic       clk;
    logic       reset;
    logic [7:0] adc_data;
    logic       adc_valid;
    logic       fault_clr;
    logic       T_media, T_alta, alarm_latched;
    logic [1:0] level;
    logic       T_media1, T_alta1, alarm_latched1;
    logic [1:0] level1;
    int         n_checks = 0;
    int         n_fail   = 0;

    temp_level_classifier dut (
        .clk           (clk),
        .reset         (reset),
        .adc_data      (adc_data),
        .adc_valid     (adc_valid),
        .fault_clr     (fault_clr),
        .T_media       (T_media),
        .T_alta        (T_alta),
        .level         (level),
        .alarm_latched (alarm_latched)
    );

    temp_level_classifier #(.PERSIST(1)) dut1 (
        .clk           (clk),
        .reset         (reset),
        .adc_data      (adc_data),
        .adc_valid     (adc_valid),
        .fault_clr     (fault_clr),
        .T_media       (T_media1),
        .T_alta        (T_alta1),
        .level         (level1),
        .alarm_latched (alarm_latched1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        reset = 1'b1;
        adc_valid = 1'b0;
        fault_clr = 1'b0;
        adc_data = 8'd0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic sample(input logic [7:0] v, input int reps);
        for (int i = 0; i < reps; i++) begin
            adc_data = v;
            adc_valid = 1'b1;
            @(posedge clk);
            #1;
            adc_valid = 1'b0;
        end
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({level, T_media, T_alta, alarm_latched} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_init: got %b expected 00000", {level, T_media, T_alta, alarm_latched});
        end
        sample(8'd200, 4);
        n_checks++;
        if (level !== 2'b10 || alarm_latched !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_pre_alta: got level=%b alarm=%b expected 10/1", level, alarm_latched);
        end
        #3;
        reset = 1'b1;
        #1;
        n_checks++;
        if ({level, T_media, T_alta, alarm_latched} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_async: got %b expected 00000", {level, T_media, T_alta, alarm_latched});
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        sample(8'd100, 3);
        do_reset();
        sample(8'd100, 3);
        n_checks++;
        if (level !== 2'b00 || T_media !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_run_discard: got level=%b T_media=%b expected 00/0", level, T_media);
        end
    endtask

    task automatic test_rise();
        do_reset();
        sample(8'd100, 3);
        n_checks++;
        if (level !== 2'b00) begin
            n_fail++;
            $display("FAIL rise_3rd: got %b expected 00", level);
        end
        sample(8'd100, 1);
        n_checks++;
        if (level !== 2'b01 || T_media !== 1'b1 || T_alta !== 1'b0) begin
            n_fail++;
            $display("FAIL rise_4th: got level=%b T_media=%b T_alta=%b expected 01/1/0", level, T_media, T_alta);
        end
        do_reset();
        sample(8'd100, 3);
        sample(8'd50, 1);
        sample(8'd100, 1);
        n_checks++;
        if (level !== 2'b00) begin
            n_fail++;
            $display("FAIL rise_broken: got %b expected 00", level);
        end
    endtask

    task automatic test_hysteresis();
        do_reset();
        sample(8'd100, 4);
        sample(8'd90, 10);
        n_checks++;
        if (level !== 2'b01) begin
            n_fail++;
            $display("FAIL hyst_media_hold: got %b expected 01", level);
        end
        sample(8'd88, 4);
        n_checks++;
        if (level !== 2'b01) begin
            n_fail++;
            $display("FAIL hyst_media_edge88: got %b expected 01", level);
        end
        sample(8'd87, 3);
        n_checks++;
        if (level !== 2'b01) begin
            n_fail++;
            $display("FAIL hyst_media_drop3: got %b expected 01", level);
        end
        sample(8'd87, 1);
        n_checks++;
        if (level !== 2'b00 || T_media !== 1'b0) begin
            n_fail++;
            $display("FAIL hyst_media_drop: got level=%b T_media=%b expected 00/0", level, T_media);
        end
        do_reset();
        sample(8'd200, 4);
        sample(8'd185, 4);
        n_checks++;
        if (level !== 2'b10) begin
            n_fail++;
            $display("FAIL hyst_alta_hold: got %b expected 10", level);
        end
        sample(8'd183, 4);
        n_checks++;
        if (level !== 2'b01 || T_media !== 1'b1 || T_alta !== 1'b0) begin
            n_fail++;
            $display("FAIL hyst_alta_drop: got level=%b T_media=%b T_alta=%b expected 01/1/0", level, T_media, T_alta);
        end
    endtask

    task automatic test_jump_gaps();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            sample(8'd200, 1);
            idle(3);
        end
        n_checks++;
        if (level !== 2'b00 || alarm_latched !== 1'b0) begin
            n_fail++;
            $display("FAIL jump_before: got level=%b alarm=%b expected 00/0", level, alarm_latched);
        end
        sample(8'd200, 1);
        n_checks++;
        if (level !== 2'b10 || T_alta !== 1'b1 || T_media !== 1'b0 || alarm_latched !== 1'b1) begin
            n_fail++;
            $display("FAIL jump_commit: got level=%b T_alta=%b T_media=%b alarm=%b expected 10/1/0/1",
                     level, T_alta, T_media, alarm_latched);
        end
    endtask

    task automatic test_alarm();
        fault_clr = 1'b1;
        idle(1);
        fault_clr = 1'b0;
        n_checks++;
        if (alarm_latched !== 1'b1) begin
            n_fail++;
            $display("FAIL alarm_clr_in_alta: got %b expected 1", alarm_latched);
        end
        sample(8'd150, 4);
        n_checks++;
        if (level !== 2'b01 || alarm_latched !== 1'b1) begin
            n_fail++;
            $display("FAIL alarm_no_queue: got level=%b alarm=%b expected 01/1", level, alarm_latched);
        end
        fault_clr = 1'b1;
        idle(1);
        fault_clr = 1'b0;
        n_checks++;
        if (alarm_latched !== 1'b0) begin
            n_fail++;
            $display("FAIL alarm_clear: got %b expected 0", alarm_latched);
        end
        sample(8'd200, 3);
        fault_clr = 1'b1;
        sample(8'd200, 1);
        fault_clr = 1'b0;
        n_checks++;
        if (level !== 2'b10 || alarm_latched !== 1'b1) begin
            n_fail++;
            $display("FAIL alarm_set_wins: got level=%b alarm=%b expected 10/1", level, alarm_latched);
        end
    endtask

    task automatic test_mixed();
        do_reset();
        sample(8'd200, 2);
        sample(8'd100, 3);
        n_checks++;
        if (level !== 2'b00) begin
            n_fail++;
            $display("FAIL mixed_5th: got %b expected 00", level);
        end
        sample(8'd100, 1);
        n_checks++;
        if (level !== 2'b01) begin
            n_fail++;
            $display("FAIL mixed_6th: got %b expected 01", level);
        end
        do_reset();
        sample(8'd96, 4);
        n_checks++;
        if (level !== 2'b01) begin
            n_fail++;
            $display("FAIL bound_96: got %b expected 01", level);
        end
        do_reset();
        sample(8'd95, 4);
        n_checks++;
        if (level !== 2'b00) begin
            n_fail++;
            $display("FAIL bound_95: got %b expected 00", level);
        end
        do_reset();
        sample(8'd255, 4);
        n_checks++;
        if (level !== 2'b10 || T_alta !== 1'b1) begin
            n_fail++;
            $display("FAIL bound_255: got level=%b T_alta=%b expected 10/1", level, T_alta);
        end
    endtask

    task automatic test_persist1();
        do_reset();
        sample(8'd100, 1);
        n_checks++;
        if (level1 !== 2'b01 || T_media1 !== 1'b1) begin
            n_fail++;
            $display("FAIL p1_media: got level=%b T_media=%b expected 01/1", level1, T_media1);
        end
        sample(8'd200, 1);
        n_checks++;
        if (level1 !== 2'b10 || T_alta1 !== 1'b1 || alarm_latched1 !== 1'b1) begin
            n_fail++;
            $display("FAIL p1_alta: got level=%b T_alta=%b alarm=%b expected 10/1/1", level1, T_alta1, alarm_latched1);
        end
        sample(8'd50, 1);
        n_checks++;
        if (level1 !== 2'b00 || T_alta1 !== 1'b0) begin
            n_fail++;
            $display("FAIL p1_normal: got level=%b T_alta=%b expected 00/0", level1, T_alta1);
        end
    endtask

    initial begin
        test_reset();
        test_rise();
        test_hysteresis();
        test_jump_gaps();
        test_alarm();
        test_mixed();
        test_persist1();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
